// File: rtl/irq_controller.sv
// irq_controller
//   Level-to-edge interrupt controller with a pending register, an enable mask
//   and a single-level (non-nesting) request/acknowledge state machine.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous active-high reset
//   MemWrite    bus write strobe for the register selected by address
//   address     register select: 0 PEND, 1 MASK, 2 STATUS, 3 EOI
//   write_data  bus write data
//   read_data   combinational read of the selected register
//   irq_in      level interrupt sources (bit 0 is the timer line)
//   cpu_irq     registered interrupt request to the CPU
//   cpu_ack     one-cycle acknowledge from the CPU (exception entry)
//   irq_id      registered index of the requested or in-service source
//
// Handshake: cpu_irq acts as "valid" and cpu_ack as "ready". A request is
// transferred on the edge where cpu_irq=1 and cpu_ack=1; until then cpu_irq
// and irq_id stay stable unless the request is withdrawn because its
// pending/enable bits dropped. cpu_ack outside a request is ignored.
//
// The FSM state is observable through the STATUS register (bits [4:3]).

module irq_controller #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [1:0]       address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [N_SRC-1:0] irq_in,
    output logic             cpu_irq,
    input  logic             cpu_ack,
    output logic [1:0]       irq_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        UNUSED  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  prev_q;
    logic [N_SRC-1:0]  pend_q, pend_d;
    logic [N_SRC-1:0]  mask_q;
    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  active;
    logic [N_SRC-1:0]  id_onehot;
    logic [1:0]        first_id;
    logic [1:0]        irq_id_d;
    logic              cpu_irq_d;
    logic              ack_clear;
    logic              pend_wr, mask_wr, eoi_wr;

    // Upper write_data bits have no storage behind them.
    logic unused_wdata;
    assign unused_wdata = ^write_data[31:N_SRC];

    assign pend_wr = MemWrite && (address == 2'd0);
    assign mask_wr = MemWrite && (address == 2'd1);
    assign eoi_wr  = MemWrite && (address == 2'd3);

    assign rise   = irq_in & ~prev_q;
    assign active = pend_q & mask_q;

    // Lowest set index of active wins (source 0 is highest priority).
    always_comb begin
        first_id = 2'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) first_id = 2'(i);
        end
    end

    // One-hot decode of the current irq_id, used for withdrawal and ack clear.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_onehot[i] = (irq_id == 2'(i));
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cpu_irq_d = cpu_irq;
        irq_id_d  = irq_id;
        ack_clear = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_irq_d = 1'b0;
                if (|active) begin
                    state_d   = REQ;
                    cpu_irq_d = 1'b1;
                    irq_id_d  = first_id;
                end
            end
            REQ: begin
                // Acknowledge beats withdrawal when both happen together.
                if (cpu_ack) begin
                    state_d   = SERVICE;
                    cpu_irq_d = 1'b0;
                    ack_clear = 1'b1;
                end else if (!(|(active & id_onehot))) begin
                    state_d   = IDLE;
                    cpu_irq_d = 1'b0;
                end
            end
            SERVICE: begin
                cpu_irq_d = 1'b0;
                if (eoi_wr) state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                cpu_irq_d = 1'b0;
            end
        endcase
    end

    // Pending update: W1C and ack clear first, then a new edge re-sets the bit,
    // so a same-cycle rise always survives.
    always_comb begin
        pend_d = pend_q;
        if (pend_wr)   pend_d = pend_d & ~write_data[N_SRC-1:0];
        if (ack_clear) pend_d = pend_d & ~id_onehot;
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clk) begin
        // Tracks irq_in even in reset so a line high at release makes no edge.
        prev_q <= irq_in;
        if (reset) begin
            pend_q  <= '0;
            mask_q  <= '0;
            state_q <= IDLE;
            cpu_irq <= 1'b0;
            irq_id  <= 2'd0;
        end else begin
            pend_q  <= pend_d;
            if (mask_wr) mask_q <= write_data[N_SRC-1:0];
            state_q <= state_d;
            cpu_irq <= cpu_irq_d;
            irq_id  <= irq_id_d;
        end
    end

    always_comb begin
        read_data = 32'd0;
        case (address)
            2'd0:    read_data = 32'(pend_q);
            2'd1:    read_data = 32'(mask_q);
            2'd2:    read_data = {27'd0, state_q, 1'b0, irq_id};
            default: read_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed vectors, scoreboard queues for
// register/level checks and for CPU interrupt requests, single monitor process.

module tb_irq_controller;

  localparam int N_SRC = 4;

  logic             clk;
  logic             reset;
  logic             MemWrite;
  logic [1:0]       address;
  logic [31:0]      write_data;
  logic [31:0]      read_data;
  logic [N_SRC-1:0] irq_in;
  logic             cpu_irq;
  logic             cpu_ack;
  logic [1:0]       irq_id;

  irq_controller #(.N_SRC(N_SRC)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .irq_in     (irq_in),
    .cpu_irq    (cpu_irq),
    .cpu_ack    (cpu_ack),
    .irq_id     (irq_id)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [31:0] exp_q[$];
  int          kind_q[$];   // 0: read_data, 1: cpu_irq level
  string       name_q[$];
  logic [1:0]  irq_exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        rd_strobe = 1'b0;
  logic        done = 1'b0;
  logic        report_ready = 1'b0;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    MemWrite   = 1'b1;
    address    = a;
    write_data = d;
    tick(1);
    MemWrite   = 1'b0;
    write_data = 32'd0;
  endtask

  task automatic check_reg(input string nm, input logic [1:0] a, input logic [31:0] e);
    address = a;
    exp_q.push_back(e);
    kind_q.push_back(0);
    name_q.push_back(nm);
    #1 rd_strobe = 1'b1;
    #1 rd_strobe = 1'b0;
  endtask

  task automatic check_irq(input string nm, input logic e);
    exp_q.push_back({31'd0, e});
    kind_q.push_back(1);
    name_q.push_back(nm);
    #1 rd_strobe = 1'b1;
    #1 rd_strobe = 1'b0;
  endtask

  task automatic expect_req(input logic [1:0] id);
    irq_exp_q.push_back(id);
  endtask

  // monitor: compares on check strobes and on every rising cpu_irq
  initial begin : monitor
    logic        last_irq;
    logic [31:0] e, act;
    int          k;
    string       nm;
    logic [1:0]  eid;
    last_irq = 1'b0;
    forever begin
      @(negedge clk or posedge rd_strobe or posedge done);
      if (done) begin
        while (irq_exp_q.size() > 0) begin
          eid = irq_exp_q.pop_front();
          n_vec++;
          n_err++;
          $display("FAIL missing_request: got no cpu_irq, expected irq_id=%0d", eid);
        end
        report_ready = 1'b1;
        break;
      end else if (rd_strobe) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_underflow: check strobe with empty expected queue");
        end else begin
          e  = exp_q.pop_front();
          k  = kind_q.pop_front();
          nm = name_q.pop_front();
          act = (k == 0) ? read_data : {31'd0, cpu_irq};
          n_vec++;
          if (act !== e) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, e);
          end
        end
      end else if (!clk) begin
        if (cpu_irq === 1'b1 && last_irq === 1'b0) begin
          n_vec++;
          if (irq_exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_request: cpu_irq rose with irq_id=%0d, none expected", irq_id);
          end else begin
            eid = irq_exp_q.pop_front();
            if (irq_id !== eid) begin
              n_err++;
              $display("FAIL request_id: got irq_id=%0d, expected %0d", irq_id, eid);
            end
          end
        end
        last_irq = cpu_irq;
      end
    end
  end

  // stimulus
  initial begin
    reset      = 1'b1;
    MemWrite   = 1'b0;
    address    = 2'd0;
    write_data = 32'd0;
    irq_in     = '0;
    cpu_ack    = 1'b0;
    tick(2);
    reset = 1'b0;
    check_reg("rst_pend",   2'd0, 32'h0);
    check_reg("rst_mask",   2'd1, 32'h0);
    check_reg("rst_status", 2'd2, 32'h0);
    check_reg("rst_eoi",    2'd3, 32'h0);
    check_irq("rst_cpu_irq", 1'b0);

    // single pulse on the timer line
    bus_write(2'd1, 32'h1);
    check_reg("t1_mask", 2'd1, 32'h1);
    expect_req(2'd0);
    irq_in = 4'b0001;
    tick(1);
    irq_in = 4'b0000;
    check_reg("t1_pend_set", 2'd0, 32'h1);
    check_irq("t1_no_irq_yet", 1'b0);
    tick(1);
    check_irq("t1_irq_high", 1'b1);
    check_reg("t1_status_req", 2'd2, 32'h08);
    cpu_ack = 1'b1;
    tick(1);
    cpu_ack = 1'b0;
    check_irq("t1_irq_low", 1'b0);
    check_reg("t1_status_svc", 2'd2, 32'h10);
    check_reg("t1_pend_clr", 2'd0, 32'h0);
    bus_write(2'd3, 32'h0);
    check_reg("t1_status_idle", 2'd2, 32'h0);

    // two sources rise together: priority, then follow-up after EOI
    bus_write(2'd1, 32'hF);
    expect_req(2'd1);
    expect_req(2'd3);
    irq_in = 4'b1010;
    tick(2);
    check_reg("t2_status_req1", 2'd2, 32'h09);
    cpu_ack = 1'b1;
    tick(1);
    cpu_ack = 1'b0;
    check_reg("t2_pend_after_ack", 2'd0, 32'h8);
    check_reg("t2_status_svc1", 2'd2, 32'h11);
    bus_write(2'd3, 32'h0);
    check_reg("t2_status_idle", 2'd2, 32'h01);
    check_irq("t2_gap_low", 1'b0);
    tick(1);
    check_irq("t2_irq3_high", 1'b1);
    check_reg("t2_status_req3", 2'd2, 32'h0B);
    cpu_ack = 1'b1;
    tick(1);
    cpu_ack = 1'b0;
    bus_write(2'd3, 32'h0);
    irq_in = 4'b0000;
    tick(1);
    check_reg("t2_pend_empty", 2'd0, 32'h0);

    // held level produces a single edge
    bus_write(2'd1, 32'h1);
    expect_req(2'd0);
    irq_in = 4'b0001;
    tick(1);
    check_reg("t3_pend_set", 2'd0, 32'h1);
    tick(1);
    cpu_ack = 1'b1;
    tick(1);
    cpu_ack = 1'b0;
    tick(17);
    check_reg("t3_pend_once", 2'd0, 32'h0);
    bus_write(2'd3, 32'h0);
    tick(3);
    check_irq("t3_no_second_req", 1'b0);
    check_reg("t3_pend_still_clr", 2'd0, 32'h0);
    irq_in = 4'b0000;
    tick(1);

    // withdrawal by masking, re-request, ack beats withdrawal
    bus_write(2'd1, 32'h4);
    expect_req(2'd2);
    irq_in = 4'b0100;
    tick(2);
    check_reg("t4_status_req", 2'd2, 32'h0A);
    bus_write(2'd1, 32'h0);
    tick(1);
    check_irq("t4_withdrawn", 1'b0);
    check_reg("t4_status_idle", 2'd2, 32'h02);
    check_reg("t4_pend_kept", 2'd0, 32'h4);
    expect_req(2'd2);
    bus_write(2'd1, 32'h4);
    tick(1);
    check_irq("t4_rerequest", 1'b1);
    check_reg("t4_status_rereq", 2'd2, 32'h0A);
    bus_write(2'd1, 32'h0);
    cpu_ack = 1'b1;
    tick(1);
    cpu_ack = 1'b0;
    check_reg("t4_ack_wins", 2'd2, 32'h12);
    check_reg("t4_pend_clr", 2'd0, 32'h0);
    check_irq("t4_irq_low", 1'b0);
    bus_write(2'd3, 32'h0);
    irq_in = 4'b0000;
    tick(1);

    // same-cycle rise and W1C, register write masking
    irq_in     = 4'b0010;
    MemWrite   = 1'b1;
    address    = 2'd0;
    write_data = 32'h2;
    tick(1);
    MemWrite   = 1'b0;
    write_data = 32'd0;
    check_reg("t5_set_wins", 2'd0, 32'h2);
    bus_write(2'd0, 32'h2);
    check_reg("t5_w1c", 2'd0, 32'h0);
    bus_write(2'd1, 32'hFFFF_FFF0);
    check_reg("t5_mask_upper", 2'd1, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    check_reg("t5_status_ro", 2'd2, 32'h02);
    irq_in = 4'b0000;
    tick(1);

    // line high through reset, then reset while in service
    reset  = 1'b1;
    irq_in = 4'b0001;
    tick(2);
    reset = 1'b0;
    bus_write(2'd1, 32'h1);
    tick(3);
    check_reg("t6_no_edge_pend", 2'd0, 32'h0);
    check_irq("t6_no_edge_irq", 1'b0);
    irq_in = 4'b0000;
    tick(1);
    expect_req(2'd0);
    irq_in = 4'b0001;
    tick(2);
    cpu_ack = 1'b1;
    tick(1);
    cpu_ack = 1'b0;
    check_reg("t6_status_svc", 2'd2, 32'h10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_reg("t6_status_rst", 2'd2, 32'h0);
    check_irq("t6_irq_rst", 1'b0);
    check_reg("t6_pend_rst", 2'd0, 32'h0);
    check_reg("t6_mask_rst", 2'd1, 32'h0);
    irq_in = 4'b0000;
    tick(3);

    done = 1'b1;
    wait (report_ready);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_checks: %0d checks left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N_SRC, default 4: number of interrupt sources, legal range 1..4.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 MemWrite  input  1  bus write strobe for the register selected by address.
REQ-005 address  input  2  register select: 0 PEND, 1 MASK, 2 STATUS, 3 EOI.
REQ-006 write_data  input  32  bus write data.
REQ-007 read_data  output  32  combinational read of the selected register.
REQ-008 irq_in  input  N_SRC  level interrupt sources; bit 0 is the timer IRQ line.
REQ-009 cpu_irq  output  1  interrupt request to the CPU, registered.
REQ-010 cpu_ack  input  1  one-cycle CPU acknowledge of cpu_irq (exception entry).
REQ-011 irq_id  output  2  index of the requested or in-service source, registered.

Function
REQ-012 Edge detect: prev[N_SRC-1:0] <= irq_in every cycle; rise[i] = irq_in[i] & ~prev[i].
REQ-013 PEND[i] sets on rise[i]; a bus write to address 0 clears each PEND bit whose write_data bit is 1 (write-1-to-clear).
REQ-014 Same-cycle rise[i] and W1C of PEND[i]: set wins, PEND[i] = 1.
REQ-015 MASK (address 1) is read/write over bits [N_SRC-1:0]; 1 = enabled; upper bits read 0 and ignore writes.
REQ-016 STATUS (address 2) reads {27'b0, state[1:0] at bits[4:3], 1'b0, irq_id at bits[1:0]}; writes ignored.
REQ-017 EOI (address 3) reads 0; any bus write to it is an end-of-interrupt event.
REQ-018 PEND reads {zero-extended PEND}; unused bits read 0.
REQ-019 State machine states: IDLE=0, REQ=1, SERVICE=2; encoding 3 is unreachable and SHALL go to IDLE.
REQ-020 IDLE: if (PEND & MASK) != 0, next state REQ, irq_id <= lowest set index of (PEND & MASK) (index 0 highest priority), cpu_irq <= 1.
REQ-021 REQ: cpu_irq held 1 and irq_id held stable until cpu_ack or withdrawal.
REQ-022 REQ with cpu_ack=1: next state SERVICE, cpu_irq <= 0, PEND[irq_id] <= 0 (unless a new rise on that source in the same cycle, which sets it).
REQ-023 REQ withdrawal: if PEND[irq_id] & MASK[irq_id] becomes 0 with no cpu_ack, next state IDLE, cpu_irq <= 0; cpu_ack in the same cycle takes priority over withdrawal.
REQ-024 SERVICE: cpu_irq = 0; no nesting; new edges still accumulate in PEND; EOI write -> IDLE.
REQ-025 EOI write while in IDLE or REQ has no effect.
REQ-026 cpu_ack outside REQ is ignored.
REQ-027 Minimum latency: irq_in rise at edge k -> PEND set at edge k+1 -> cpu_irq high after edge k+2.
REQ-028 After EOI the next request is raised one cycle after IDLE is re-entered if any PEND&MASK bit is set.

Reset
REQ-029 On reset: PEND=0, MASK=0, state=IDLE, cpu_irq=0, irq_id=0.
REQ-030 During reset prev <= irq_in, so a source already high at reset release produces no edge.
REQ-031 Reset asserted in REQ or SERVICE returns to IDLE the next edge, dropping cpu_irq and any in-service source.

Verification
REQ-032 MASK=1, pulse irq_in[0] high -> PEND=1 after 1 edge, cpu_irq=1, irq_id=0 after 2 edges; cpu_ack -> cpu_irq=0, STATUS=0x10, PEND=0.
REQ-033 MASK=0xF, irq_in=4'b1010 rising together -> irq_id=1 first; ack, EOI -> irq_id=3 request raised next cycle.
REQ-034 irq_in[0] held high 20 cycles with MASK=1 -> PEND[0] set exactly once; ack, EOI -> no second request.
REQ-035 In REQ for source 2, write MASK=0 -> cpu_irq=0 next edge, state IDLE, PEND[2] still 1; write MASK=4 -> request reappears with irq_id=2.
REQ-036 Same cycle: rise on irq_in[1] and W1C write 0x2 to PEND -> PEND[1]=1; cpu_ack coincident with MASK clear in REQ -> SERVICE.
REQ-037 irq_in[0] high during reset, reset released, MASK=1 -> PEND stays 0 and cpu_irq stays 0; reset asserted in SERVICE -> STATUS=0, cpu_irq=0.
